// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format constants and the encoded-entry layout.
// The extender decodes with the same IMM_* select values.
package imm_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_t;

  localparam int ENC_W = $bits(enc_t);

  // True when v[31:lsb] are all equal, i.e. v survives truncation to a signed (lsb+1)-bit field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] s;
    s = 32'($signed(v) >>> lsb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_enc_fifo.sv
// 2-entry FIFO with registered head; latency 1 from push to out_valid.
// in_ready drops only when full; no pass-through, so a full queue never accepts.
module imm_enc_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count;
  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = slot0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_data;
          else               slot1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Push while popping can only happen with one entry held (full blocks push).
          if (count == 2'd1) begin
            slot0 <= in_data;
          end else begin
            slot0 <= slot1;
            slot1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Scatters an immediate into RV32I I/S/B/U/J fields of a skeleton and flags unrepresentable values.
// Latency 1 through a 2-entry queue; in_ready low only when the queue is full.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          skel,
  input  logic [31:0]          imm,
  input  logic [2:0]           imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  function automatic enc_t encode(input logic [31:0] s, input logic [31:0] v, input logic [2:0] src);
    enc_t r;
    r.instr = s;
    r.err   = 1'b0;
    case (src)
      IMM_I: begin
        r.instr[31:20] = v[11:0];
        r.err          = !fits_signed(v, 11);
      end
      IMM_S: begin
        r.instr[31:25] = v[11:5];
        r.instr[11:7]  = v[4:0];
        r.err          = !fits_signed(v, 11);
      end
      IMM_B: begin
        r.instr[31]    = v[12];
        r.instr[30:25] = v[10:5];
        r.instr[11:8]  = v[4:1];
        r.instr[7]     = v[11];
        r.err          = !fits_signed(v, 12) || v[0];
      end
      IMM_U: begin
        r.instr[31:12] = v[31:12];
        r.err          = (v[11:0] != 12'd0);
      end
      IMM_J: begin
        r.instr[31]    = v[20];
        r.instr[30:21] = v[10:1];
        r.instr[20]    = v[11];
        r.instr[19:12] = v[19:12];
        r.err          = !fits_signed(v, 20) || v[0];
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  enc_t enc;
  enc_t head;
  logic accept;

  assign enc    = encode(skel, imm, imm_src);
  assign accept = in_valid && in_ready;

  imm_enc_fifo #(.W(ENC_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_instr = head.instr;
  assign out_err   = head.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && enc.err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and round-trip checks for imm_encoder against hand-computed encodings.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] skel;
  logic [31:0] imm;
  logic [2:0]  imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .skel      (skel),
    .imm       (imm),
    .imm_src   (imm_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] skel;
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference immediate extender (decode direction).
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b011:  return {i[31:12], 12'b0};
      3'b100:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic drive(input logic [31:0] s, input logic [31:0] v, input logic [2:0] src);
    skel     = s;
    imm      = v;
    imm_src  = src;
    in_valid = 1'b1;
  endtask

  vec_t vecs[12];
  int   exp_cnt;

  initial begin
    vecs[0]  = '{32'h0000_0093, 32'hFFFF_FFFF, 3'b000, 32'hFFF0_0093, 1'b0};
    vecs[1]  = '{32'h0000_0093, 32'h0000_0800, 3'b000, 32'h8000_0093, 1'b1};
    vecs[2]  = '{32'h0000_0063, 32'h0000_0005, 3'b010, 32'h0000_0263, 1'b1};
    vecs[3]  = '{32'h1234_5678, 32'h0000_0000, 3'b111, 32'h1234_5678, 1'b1};
    vecs[4]  = '{32'h0000_2023, 32'hFFFF_FFF8, 3'b001, 32'hFE00_2C23, 1'b0};
    vecs[5]  = '{32'h0000_2023, 32'h0000_07FF, 3'b001, 32'h7E00_2FA3, 1'b0};
    vecs[6]  = '{32'h0000_2023, 32'hFFFF_F800, 3'b001, 32'h8000_2023, 1'b0};
    vecs[7]  = '{32'h0000_0037, 32'h0000_0001, 3'b011, 32'h0000_0037, 1'b1};
    vecs[8]  = '{32'h0000_00EF, 32'h0010_0000, 3'b100, 32'h8000_00EF, 1'b1};
    vecs[9]  = '{32'h0000_00EF, 32'hFFF0_0000, 3'b100, 32'h8000_00EF, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 32'h000F_FFFF, 1'b0};
    vecs[11] = '{32'hABCD_0000, 32'h0000_0000, 3'b101, 32'hABCD_0000, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    skel = '0; imm = '0; imm_src = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single-shot table with out_ready=1.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].skel, vecs[i].imm, vecs[i].src);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (vecs[i].exp_err) exp_cnt++;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vecs[i].exp_instr));
      chk($sformatf("vec%0d_err", i),   64'(out_err),   64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cnt", i),   64'(err_count), 64'(exp_cnt));
    end
    @(posedge clk); #1;
    chk("table_drained", 64'(out_valid), 64'd0);

    // B/U/J back-to-back.
    drive(32'h0000_0063, 32'hFFFF_FFFC, 3'b010);
    @(posedge clk); #1;
    drive(32'h0000_02B7, 32'h1234_5000, 3'b011);
    chk("b2b_B", {31'd0, out_valid, out_err, out_instr}, {31'd0, 1'b1, 1'b0, 32'hFE00_0EE3});
    @(posedge clk); #1;
    drive(32'h0000_00EF, 32'h0000_0800, 3'b100);
    chk("b2b_U", {31'd0, out_valid, out_err, out_instr}, {31'd0, 1'b1, 1'b0, 32'h1234_52B7});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_J", {31'd0, out_valid, out_err, out_instr}, {31'd0, 1'b1, 1'b0, 32'h0010_00EF});
    @(posedge clk); #1;
    chk("b2b_drained", 64'(out_valid), 64'd0);

    // Backpressure: fill, block the third, then drain in order.
    out_ready = 1'b0;
    drive(32'h0000_0013, 32'd1, 3'b000);
    @(posedge clk); #1;
    drive(32'h0000_0013, 32'd2, 3'b000);
    @(posedge clk); #1;
    chk("bp_full", 64'(in_ready), 64'd0);
    drive(32'h0000_0013, 32'd3, 3'b000);
    @(posedge clk); #1;
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_head_stable", {31'd0, out_valid, out_err, out_instr}, {31'd0, 1'b1, 1'b0, 32'h0010_0013});
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_head2", 64'(out_instr), 64'h0020_0013);
    chk("bp_ready_again", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_head3", {31'd0, out_valid, out_err, out_instr}, {31'd0, 1'b1, 1'b0, 32'h0030_0013});
    @(posedge clk); #1;
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Saturation of the error counter.
    drive(32'h0000_0000, 32'd0, 3'b111);
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("sat_cnt", 64'(err_count), 64'hFF);
    @(posedge clk); #1;

    // Reset with two queued entries.
    out_ready = 1'b0;
    drive(32'h0000_0013, 32'd1, 3'b000);
    @(posedge clk); #1;
    drive(32'h0000_0013, 32'd2, 3'b000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_full", 64'({out_valid, in_ready}), 64'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt",   64'(err_count), 64'd0);
    chk("mid_rst_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);

    // Round trip of random legal immediates through the reference extender.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] r;
      logic [31:0] v;
      logic [2:0]  src;
      r   = $urandom;
      src = 3'($urandom_range(0, 4));
      case (src)
        3'b000, 3'b001: v = {{20{r[11]}}, r[11:0]};
        3'b010:         v = {{19{r[12]}}, r[12:1], 1'b0};
        3'b011:         v = {r[31:12], 12'b0};
        default:        v = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      drive($urandom, v, src);
      @(posedge clk); #1;
      chk($sformatf("rt%0d", i), {30'd0, out_valid, out_err, extend(out_instr, src)},
          {30'd0, 1'b1, 1'b0, v});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
